// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver.
//   Synchronizes and deglitches the PS/2 clock, then frames 11-bit
//   transfers (start, 8 data LSB first, odd parity, stop). It also folds the
//   0xE0 (extended) and 0xF0 (break) prefixes into a single key event word.
// Ports:
//   clk_sys    system clock, rising edge
//   RESET      asynchronous active-high reset
//   ps2_clk    raw PS/2 clock (asynchronous)
//   ps2_data   raw PS/2 data (asynchronous)
//   ps2_key    [10] toggle, [9] pressed, [8] extended, [7:0] scan code
//   frame_err  one-cycle pulse when a frame is discarded
module ps2_key_rx #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 60000
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [WDW-1:0] WD_LIMIT  = WDW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Two-flop synchronizers; idle bus level is high.
  logic clk_s1, clk_s2, dat_s1, dat_s2;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Clock filter: flip only after FILTER_LEN consecutive differing samples.
  logic           clk_filt;
  logic           clk_filt_prev;
  logic [FCW-1:0] filt_cnt;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      clk_filt      <= 1'b1;
      clk_filt_prev <= 1'b1;
      filt_cnt      <= '0;
    end else begin
      clk_filt_prev <= clk_filt;
      if (clk_s2 != clk_filt) begin
        if (filt_cnt == FILT_LAST) begin
          clk_filt <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FCW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // Single-cycle strobe on the filtered 1->0 transition.
  logic strobe_c;
  assign strobe_c = clk_filt_prev & ~clk_filt;

  // Frame FSM state.
  state_t         state, state_next;
  logic [2:0]     bit_cnt, bit_cnt_next;
  logic [7:0]     shift, shift_next;
  logic           par, par_next;
  logic [WDW-1:0] wd, wd_next;
  logic           byte_ok_c;
  logic           err_c;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      wd      <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      shift   <= shift_next;
      par     <= par_next;
      wd      <= wd_next;
    end
  end

  // Next-state logic; a strobe takes priority over the watchdog expiring.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    par_next     = par;
    wd_next      = '0;
    byte_ok_c    = 1'b0;
    err_c        = 1'b0;

    if (strobe_c) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shift_next = {dat_s2, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            state_next   = PARITY;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          par_next   = dat_s2;
          state_next = STOP;
        end
        STOP: begin
          state_next   = IDLE;
          bit_cnt_next = '0;
          if ((^{shift, par}) && dat_s2) begin
            byte_ok_c = 1'b1;
          end else begin
            err_c = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (wd == WD_LIMIT) begin
        state_next   = IDLE;
        bit_cnt_next = '0;
        shift_next   = '0;
        par_next     = 1'b0;
        err_c        = 1'b1;
      end else begin
        wd_next = wd + WDW'(1);
      end
    end
  end

  // Byte decode: prefixes, ignored protocol bytes and key events.
  logic ext_flag, brk_flag;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      ps2_key   <= '0;
      frame_err <= 1'b0;
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
    end else begin
      frame_err <= err_c;
      if (byte_ok_c) begin
        case (shift)
          8'hE0: ext_flag <= 1'b1;
          8'hF0: brk_flag <= 1'b1;
          8'hE1: ;
          8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
          end
          default: begin
            ps2_key  <= {~ps2_key[10], ~brk_flag, ext_flag, shift};
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: number of consecutive equal synchronized samples required before the filtered PS/2 clock changes state.
REQ-002 Parameter TIMEOUT, default 60000: number of clk_sys cycles without a falling edge mid-frame before the frame is aborted.
REQ-003 clk_sys  input  1  system clock; all logic on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock, asynchronous to clk_sys.
REQ-006 ps2_data  input  1  raw PS/2 data, asynchronous to clk_sys.
REQ-007 ps2_key  output  11  key event; fields are [10] toggle, [9] pressed, [8] extended, [7:0] scan code.
REQ-008 frame_err  output  1  one-cycle pulse on a discarded frame.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-010 Clock filter: the filtered clock SHALL take the synchronized value only after FILTER_LEN consecutive cycles differing from its current value; any shorter excursion SHALL be ignored.
REQ-011 Sample strobe SHALL be the single cycle in which the filtered clock goes 1->0; data is taken from the synchronized ps2_data in that cycle.
REQ-012 Frame FSM states are IDLE, DATA, PARITY, STOP.
REQ-013 Transitions:
- IDLE: a strobe with data 0 goes to DATA with the bit counter at 0; a strobe with data 1 stays in IDLE, with no error.
- DATA: shift the data in LSB first; after the 8th bit, go to PARITY.
- PARITY: latch the parity bit, go to STOP.
- STOP: always return to IDLE.
REQ-014 Byte accepted at the STOP strobe only if the 8 data bits plus the parity bit contain an odd number of ones and the stop bit is 1; otherwise frame_err SHALL pulse for 1 cycle and the byte SHALL be dropped.
REQ-015 Watchdog: in any state other than IDLE, a counter SHALL count cycles since the last strobe.
- When the count reaches TIMEOUT: return to IDLE, pulse frame_err, discard partial data.
- A strobe in the same cycle as timeout SHALL win: the counter clears and the frame continues.
REQ-016 Prefix flags (ext_flag, brk_flag):
- An accepted 0xE0 sets ext_flag.
- An accepted 0xF0 sets brk_flag.
- Neither prefix byte updates ps2_key.
REQ-017 Any other accepted byte SHALL update ps2_key as follows, then clear both flags:
- [10] = inverted [10]
- [9] = ~brk_flag
- [8] = ext_flag
- [7:0] = byte
REQ-018 Accepted bytes 0xE1, 0xFA, 0xAA, 0xEE, 0xFE, 0x00 and 0xFF SHALL NOT update ps2_key; 0xE1 leaves the flags unchanged, and the others clear both flags.
REQ-019 ps2_key SHALL update exactly 1 cycle after the STOP strobe, and SHALL hold constant between updates.
REQ-020 A rejected frame (parity, stop bit or timeout) SHALL NOT alter the flags.

Reset
REQ-021 While RESET is high, all of the following SHALL hold:
- ps2_key = 0, frame_err = 0, both flags = 0;
- FSM in IDLE, bit counter = 0, watchdog = 0;
- filtered clock = 1, filter counter = 0, synchronizer flops = 1.
REQ-022 RESET asserted mid-frame SHALL abort the frame with no frame_err pulse.
REQ-023 After RESET deasserts, the first falling edge of the filtered clock SHALL be treated as a potential start bit.

Verification
REQ-024 From reset, send frame 0x1C with parity 0 and stop 1 -> ps2_key = 0x61C one cycle after the STOP strobe; frame_err stays 0.
REQ-025 Following REQ-024, send 0xE0 (parity 0), 0xF0 (parity 1), 0x75 (parity 0) -> ps2_key stays 0x61C until the third frame, then becomes 0x175.
REQ-026 Send 0x29 with parity bit 1 (wrong) -> frame_err high for exactly 1 cycle; ps2_key unchanged.
REQ-027 Drive a 3-cycle low glitch on ps2_clk while idle (FILTER_LEN = 8) -> no strobe and FSM stays IDLE; a following valid 0x16 frame yields code 0x16 with the toggle flipped.
REQ-028 Stop the clock after 4 data bits for TIMEOUT cycles -> frame_err pulse at count TIMEOUT and FSM returns to IDLE; the next valid 0x16 frame decodes correctly.
REQ-029 Assert RESET after 5 data bits of a frame -> ps2_key = 0 and no frame_err; after release, a valid 0x1C frame gives 0x61C.
